// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves load-use, branch,
// mult/div and data-memory-wait hazards into register enables, flushes and bubbles.
module pipeline_ctrl #(
    parameter int REG_NUM_W    = 5,
    parameter int BR_FLUSH_CYC = 1,
    parameter int MD_TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_NUM_W-1:0] ifidRS,
    input  logic [REG_NUM_W-1:0] ifidRT,
    input  logic                 ifidUsesRT,
    input  logic [REG_NUM_W-1:0] idexRT,
    input  logic                 idexIsLoad,
    input  logic                 brTaken,
    input  logic                 mdReq,
    input  logic                 mdDone,
    input  logic                 exmemIsMem,
    input  logic                 dmemReady,
    output logic                 pcWrEn,
    output logic                 ifidWrEn,
    output logic                 ifidFlush,
    output logic                 idexWrEn,
    output logic                 idexBubble,
    output logic                 exmemWrEn,
    output logic                 mdStart,
    output logic                 mdErr,
    output logic [1:0]           ctrlState,
    output logic [15:0]          stallCnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MD_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(BR_FLUSH_CYC - 1);
    localparam logic [9:0] MD_LAST    = 10'(MD_TIMEOUT - 1);

    state_t     state;
    logic [3:0] flush_cnt;
    logic [9:0] md_cnt;
    logic       load_use;
    logic       mem_freeze;
    logic       md_timeout;

    assign load_use   = idexIsLoad && (idexRT != '0) &&
                        ((idexRT == ifidRS) || (ifidUsesRT && (idexRT == ifidRT)));
    assign mem_freeze = exmemIsMem && !dmemReady;
    assign md_timeout = (md_cnt == MD_LAST);
    assign ctrlState  = state;

    always_comb begin
        pcWrEn     = 1'b0;
        ifidWrEn   = 1'b0;
        ifidFlush  = 1'b0;
        idexWrEn   = 1'b0;
        idexBubble = 1'b0;
        exmemWrEn  = 1'b0;
        mdStart    = 1'b0;
        if (rst) begin
            ifidFlush = 1'b1;
        end else if (!mem_freeze) begin
            // Every non-frozen cycle lets EX/MEM and ID/EX move; only the front end varies.
            exmemWrEn = 1'b1;
            idexWrEn  = 1'b1;
            case (state)
                RUN: begin
                    if (brTaken) begin
                        pcWrEn     = 1'b1;
                        ifidWrEn   = 1'b1;
                        ifidFlush  = 1'b1;
                        idexBubble = 1'b1;
                    end else if (mdReq) begin
                        mdStart    = 1'b1;
                        idexBubble = 1'b1;
                    end else if (load_use) begin
                        idexBubble = 1'b1;
                    end else begin
                        pcWrEn   = 1'b1;
                        ifidWrEn = 1'b1;
                    end
                end
                FLUSH: begin
                    pcWrEn     = 1'b1;
                    ifidWrEn   = 1'b1;
                    ifidFlush  = 1'b1;
                    idexBubble = 1'b1;
                end
                MD_WAIT: begin
                    if (mdDone || md_timeout) begin
                        pcWrEn   = 1'b1;
                        ifidWrEn = 1'b1;
                    end else begin
                        idexBubble = 1'b1;
                    end
                end
                default: begin
                    idexBubble = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
            md_cnt    <= '0;
            mdErr     <= 1'b0;
            stallCnt  <= '0;
        end else begin
            if (!pcWrEn && (stallCnt != 16'hFFFF)) begin
                stallCnt <= stallCnt + 16'd1;
            end
            // A memory freeze stalls the sequencer and the watchdog alike.
            if (!mem_freeze) begin
                case (state)
                    RUN: begin
                        if (brTaken) begin
                            if (BR_FLUSH_CYC > 1) begin
                                state     <= FLUSH;
                                flush_cnt <= FLUSH_INIT;
                            end
                        end else if (mdReq) begin
                            state  <= MD_WAIT;
                            md_cnt <= '0;
                        end
                    end
                    FLUSH: begin
                        if (flush_cnt == 4'd1) begin
                            state <= RUN;
                        end
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                    MD_WAIT: begin
                        if (mdDone) begin
                            state <= RUN;
                        end else if (md_timeout) begin
                            mdErr <= 1'b1;
                            state <= RUN;
                        end else begin
                            md_cnt <= md_cnt + 10'd1;
                        end
                    end
                    default: begin
                        state <= RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl (BR_FLUSH_CYC=3, MD_TIMEOUT=8).
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ifidRS, ifidRT, idexRT;
    logic       ifidUsesRT, idexIsLoad, brTaken, mdReq, mdDone, exmemIsMem, dmemReady;
    logic       pcWrEn, ifidWrEn, ifidFlush, idexWrEn, idexBubble, exmemWrEn;
    logic       mdStart, mdErr;
    logic [1:0] ctrlState;
    logic [15:0] stallCnt;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .REG_NUM_W(5),
        .BR_FLUSH_CYC(3),
        .MD_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .ifidRS(ifidRS), .ifidRT(ifidRT), .ifidUsesRT(ifidUsesRT),
        .idexRT(idexRT), .idexIsLoad(idexIsLoad),
        .brTaken(brTaken), .mdReq(mdReq), .mdDone(mdDone),
        .exmemIsMem(exmemIsMem), .dmemReady(dmemReady),
        .pcWrEn(pcWrEn), .ifidWrEn(ifidWrEn), .ifidFlush(ifidFlush),
        .idexWrEn(idexWrEn), .idexBubble(idexBubble), .exmemWrEn(exmemWrEn),
        .mdStart(mdStart), .mdErr(mdErr), .ctrlState(ctrlState), .stallCnt(stallCnt)
    );

    typedef struct packed {
        logic [5:0]  en;
        logic        ms;
        logic [1:0]  st;
        logic        err;
        logic [15:0] sc;
    } exp_t;

    // {pcWrEn, ifidWrEn, ifidFlush, idexWrEn, idexBubble, exmemWrEn}
    localparam logic [5:0] NORM = 6'b110101;
    localparam logic [5:0] BR   = 6'b111111;
    localparam logic [5:0] STL  = 6'b000111;
    localparam logic [5:0] FRZ  = 6'b000000;
    localparam logic [5:0] RSTV = 6'b001000;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_sc   = '0;

    task automatic clr();
        ifidRS = '0; ifidRT = '0; idexRT = '0;
        ifidUsesRT = 1'b0; idexIsLoad = 1'b0; brTaken = 1'b0;
        mdReq = 1'b0; mdDone = 1'b0; exmemIsMem = 1'b0; dmemReady = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [5:0] en, input logic ms,
                       input logic [1:0] st, input logic err);
        exp_t e;
        exp_t act;
        e = {en, ms, st, err, exp_sc};
        sb.push_back(e);
        @(negedge clk);
        e   = sb.pop_front();
        act = {pcWrEn, ifidWrEn, ifidFlush, idexWrEn, idexBubble, exmemWrEn,
               mdStart, ctrlState, mdErr, stallCnt};
        n_assert++;
        assert (act === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, act, e);
        end
        if (rst) exp_sc = '0;
        else if (!en[5] && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", RSTV, 0, 0, 0);
        rst = 1'b0;
        chk("idle", NORM, 0, 0, 0);

        idexIsLoad = 1; idexRT = 5; ifidRS = 5;
        chk("lu_rs", STL, 0, 0, 0);
        idexIsLoad = 0;
        chk("lu_after", NORM, 0, 0, 0);
        idexIsLoad = 1; idexRT = 0; ifidRS = 0; ifidRT = 0; ifidUsesRT = 1;
        chk("lu_r0", NORM, 0, 0, 0);
        idexRT = 7; ifidRS = 3; ifidRT = 7; ifidUsesRT = 0;
        chk("lu_rt_unused", NORM, 0, 0, 0);
        ifidUsesRT = 1;
        chk("lu_rt", STL, 0, 0, 0);
        clr();
        chk("lu_clear", NORM, 0, 0, 0);

        brTaken = 1;
        chk("br_run", BR, 0, 0, 0);
        brTaken = 0;
        chk("br_flush1", BR, 0, 1, 0);
        mdReq = 1; idexIsLoad = 1; idexRT = 5; ifidRS = 5;
        chk("br_flush2", BR, 0, 1, 0);
        clr();
        chk("br_done", NORM, 0, 0, 0);

        mdReq = 1;
        chk("md_req", STL, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            brTaken = (i == 2);
            chk("md_wait", STL, 0, 2, 0);
        end
        brTaken = 0; mdDone = 1;
        chk("md_release", NORM, 0, 2, 0);
        clr();
        chk("md_after", NORM, 0, 0, 0);

        mdReq = 1;
        chk("wd_req", STL, 1, 0, 0);
        for (int i = 0; i < 7; i++) chk("wd_wait", STL, 0, 2, 0);
        chk("wd_release", NORM, 0, 2, 0);
        clr();
        chk("wd_err", NORM, 0, 0, 1);
        chk("wd_err_hold", NORM, 0, 0, 1);

        mdReq = 1;
        chk("frz_req", STL, 1, 0, 1);
        for (int i = 0; i < 2; i++) chk("frz_wait_pre", STL, 0, 2, 1);
        exmemIsMem = 1; dmemReady = 0;
        chk("frz_1", FRZ, 0, 2, 1);
        mdDone = 1;
        chk("frz_2_done_ignored", FRZ, 0, 2, 1);
        mdDone = 0;
        chk("frz_3", FRZ, 0, 2, 1);
        dmemReady = 1;
        for (int i = 0; i < 5; i++) chk("frz_wait_post", STL, 0, 2, 1);
        chk("frz_release", NORM, 0, 2, 1);
        clr();
        chk("frz_after", NORM, 0, 0, 1);

        brTaken = 1; exmemIsMem = 1; dmemReady = 0;
        chk("frz_over_br", FRZ, 0, 0, 1);
        dmemReady = 1;
        chk("br_after_frz", BR, 0, 0, 1);
        clr();
        chk("br_after_frz_f1", BR, 0, 1, 1);
        chk("br_after_frz_f2", BR, 0, 1, 1);
        chk("br_after_frz_run", NORM, 0, 0, 1);

        brTaken = 1; mdReq = 1; idexIsLoad = 1; idexRT = 5; ifidRS = 5;
        chk("prio_br", BR, 0, 0, 1);
        clr();
        chk("prio_f1", BR, 0, 1, 1);
        chk("prio_f2", BR, 0, 1, 1);
        chk("prio_run", NORM, 0, 0, 1);

        mdReq = 1;
        chk("rst_md_req", STL, 1, 0, 1);
        chk("rst_md_wait", STL, 0, 2, 1);
        rst = 1;
        chk("rst_mid_md", RSTV, 0, 2, 1);
        rst = 0; mdReq = 0;
        chk("rst_after", NORM, 0, 0, 0);

        mdReq = 1;
        chk("to_done_req", STL, 1, 0, 0);
        for (int i = 0; i < 7; i++) chk("to_done_wait", STL, 0, 2, 0);
        mdDone = 1;
        chk("to_done_release", NORM, 0, 2, 0);
        clr();
        chk("to_done_no_err", NORM, 0, 0, 0);
        chk("to_done_idle", NORM, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
